tpu_slot_sched: RTL and testbench
=================================

TPU_SLOT_SCHED -- requirements
Module: tpu_slot_sched

Interface
REQ-001 SHALL have parameter SLOTS_PER_FRAME, default 16, number of slots per frame (range 2..256).
REQ-002 SHALL have port SYS_CLK  input  1  system clock; all logic on the rising edge.
REQ-003 SHALL have port SYS_RST  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port RSTTPU  input  1  software TPU reset from the register file.
REQ-005 SHALL have port TXSLOT_EN  input  1  TX slot gating enable.
REQ-006 SHALL have port RXSLOT_EN  input  1  RX slot gating enable.
REQ-007 SHALL have port TX_SLOT  input  8  slot index for the TX gate.
REQ-008 SHALL have port RX_SLOT  input  8  slot index for the RX gate.
REQ-009 SHALL have port TIMER_INT_VALUE  input  16  slot length in SYS_CLK cycles; 0 means stopped.
REQ-010 SHALL have port int_ack  input  1  one-cycle acknowledge that clears TPU_INT.
REQ-011 SHALL have port SLOT_CNT  output  8  current slot index.
REQ-012 SHALL have port TICK_CNT  output  16  cycle count within the current slot.
REQ-013 SHALL have port slot_tick  output  1  one-cycle pulse on the first cycle of each slot.
REQ-014 SHALL have port frame_start  output  1  one-cycle pulse on the first cycle of slot 0.
REQ-015 SHALL have port TX_GATE  output  1  high for the whole TX slot.
REQ-016 SHALL have port RX_GATE  output  1  high for the whole RX slot.
REQ-017 SHALL have port TPU_INT  output  1  sticky slot interrupt.
REQ-018 SHALL have port COLLIDE  output  1  sticky flag: TX and RX were both scheduled in the same slot.

Function
REQ-019 SHALL implement a two-state FSM, IDLE and RUN; all outputs are registered.
REQ-020 IDLE SHALL hold SLOT_CNT=0, TICK_CNT=0, and drive slot_tick, frame_start, TX_GATE and RX_GATE at 0.
REQ-021 SHALL transition IDLE->RUN when RSTTPU=0 and TIMER_INT_VALUE!=0, and on that edge SHALL:
- capture TIMER_INT_VALUE, TX_SLOT, RX_SLOT, TXSLOT_EN and RXSLOT_EN into shadow registers;
- make the first RUN cycle show SLOT_CNT=0, TICK_CNT=0, slot_tick=1, frame_start=1, with gates valid for slot 0.
REQ-022 In RUN, TICK_CNT SHALL increment each cycle until it equals the shadowed period-1, then wrap to 0 on the next cycle, which is the first cycle of a new slot.
REQ-023 At each slot boundary, SLOT_CNT SHALL increment and wrap from SLOTS_PER_FRAME-1 to 0; slot_tick SHALL pulse, and frame_start SHALL pulse only when SLOT_CNT becomes 0.
REQ-024 At each slot boundary, all five shadow registers SHALL reload from the inputs, so mid-slot configuration changes take effect at the next boundary only.
REQ-025 With a shadowed period of 1, slot_tick SHALL be high every cycle and TICK_CNT SHALL stay 0.
REQ-026 If TIMER_INT_VALUE=0 at a slot boundary, the FSM SHALL go to IDLE on that edge instead of starting a new slot.
REQ-027 TX_GATE SHALL be 1 throughout a slot iff shadow TXSLOT_EN=1 and shadow TX_SLOT==SLOT_CNT.
REQ-028 RX_GATE SHALL be 1 throughout a slot iff shadow RXSLOT_EN=1, shadow RX_SLOT==SLOT_CNT, and TX_GATE is 0 in that slot (TX has priority).
REQ-029 When both enables are set and shadow TX_SLOT==RX_SLOT==SLOT_CNT, COLLIDE SHALL set and remain set until RSTTPU or SYS_RST.
REQ-030 A TX_SLOT or RX_SLOT value >= SLOTS_PER_FRAME SHALL never assert its gate.
REQ-031 TPU_INT SHALL set on every slot_tick and clear on the edge after int_ack=1; when set and ack coincide, set SHALL win.
REQ-032 RSTTPU=1 in any state SHALL, on the next edge, force IDLE, zero the counters, gates and pulses, and clear TPU_INT and COLLIDE.

Reset
REQ-033 On SYS_RST=1 at a rising edge, the block SHALL enter IDLE with every output and shadow register at 0; SYS_RST SHALL take priority over RSTTPU and int_ack.

Verification
REQ-034 SHALL cover start-up: TIMER_INT_VALUE=4, SLOTS_PER_FRAME=16, RSTTPU 1->0 -> slot_tick every 4 cycles and frame_start every 64 cycles, with SLOT_CNT wrapping 15->0.
REQ-035 SHALL cover gating: TX_SLOT=3, RX_SLOT=5, both enables=1, period 4 -> TX_GATE high exactly for the 4 cycles of slot 3, RX_GATE for slot 5, COLLIDE stays 0.
REQ-036 SHALL cover collision and range:
- TX_SLOT=RX_SLOT=2, both enabled -> TX_GATE=1 and RX_GATE=0 in slot 2, COLLIDE=1 from then on;
- TX_SLOT=200 -> TX_GATE never asserted.
REQ-037 SHALL cover a mid-slot change: TIMER_INT_VALUE 4->2 on TICK_CNT=1 -> current slot still lasts 4 cycles and following slots last 2.
REQ-038 SHALL cover interrupt handling:
- int_ack on the same cycle as slot_tick -> TPU_INT remains 1;
- int_ack one cycle later -> TPU_INT reads 0 on the following cycle.
REQ-039 SHALL cover stop and reset:
- RSTTPU=1 mid-slot -> next cycle IDLE, all outputs 0;
- TIMER_INT_VALUE=0 -> IDLE at the next boundary;
- SYS_RST mid-run -> all outputs 0.

Source files
------------

// File: rtl/tpu_slot_sched.sv
// TPU slot scheduler: divides time into fixed-length slots grouped into frames,
// raising per-slot TX/RX gates, a sticky slot interrupt and a TX/RX collision flag.
module tpu_slot_sched #(
    parameter int SLOTS_PER_FRAME = 16
) (
    input  logic        SYS_CLK,
    input  logic        SYS_RST,
    input  logic        RSTTPU,
    input  logic        TXSLOT_EN,
    input  logic        RXSLOT_EN,
    input  logic [7:0]  TX_SLOT,
    input  logic [7:0]  RX_SLOT,
    input  logic [15:0] TIMER_INT_VALUE,
    input  logic        int_ack,
    output logic [7:0]  SLOT_CNT,
    output logic [15:0] TICK_CNT,
    output logic        slot_tick,
    output logic        frame_start,
    output logic        TX_GATE,
    output logic        RX_GATE,
    output logic        TPU_INT,
    output logic        COLLIDE
);

    localparam logic [7:0] LAST_SLOT = 8'(SLOTS_PER_FRAME - 1);
    localparam logic [8:0] NUM_SLOTS = 9'(SLOTS_PER_FRAME);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state_q, state_d;
    logic [15:0] sh_period;
    logic [7:0]  sh_tx_slot, sh_rx_slot;
    logic        sh_tx_en, sh_rx_en;

    logic        boundary, load;
    logic [7:0]  slot_nxt;
    logic [7:0]  g_slot, g_tx_slot, g_rx_slot;
    logic        g_tx_en, g_rx_en, tx_hit, rx_hit;
    logic [7:0]  slot_d;
    logic [15:0] tick_d;
    logic        tick_pulse_d, frame_d, txg_d, rxg_d, int_d, col_d;

    // Out-of-range slot selectors can never match a live slot index.
    function automatic logic slot_hit(input logic en, input logic [7:0] sel,
                                      input logic [7:0] slot);
        return en && (sel == slot) && ({1'b0, sel} < NUM_SLOTS);
    endfunction

    assign boundary = (state_q == RUN) && (TICK_CNT == (sh_period - 16'd1));
    assign slot_nxt = (state_q == IDLE || SLOT_CNT == LAST_SLOT) ? 8'd0 : SLOT_CNT + 8'd1;

    always_comb begin
        state_d = state_q;
        if (RSTTPU) begin
            state_d = IDLE;
        end else if (state_q == IDLE) begin
            if (TIMER_INT_VALUE != 16'd0) state_d = RUN;
        end else if (boundary && TIMER_INT_VALUE == 16'd0) begin
            state_d = IDLE;
        end
    end

    // A new slot (first one after IDLE or each boundary) samples config from the
    // inputs; inside a slot the gates are re-derived from the shadow copies.
    always_comb begin
        load      = !RSTTPU && (state_d == RUN) && (state_q == IDLE || boundary);
        g_slot    = load ? slot_nxt   : SLOT_CNT;
        g_tx_slot = load ? TX_SLOT    : sh_tx_slot;
        g_rx_slot = load ? RX_SLOT    : sh_rx_slot;
        g_tx_en   = load ? TXSLOT_EN  : sh_tx_en;
        g_rx_en   = load ? RXSLOT_EN  : sh_rx_en;
        tx_hit    = slot_hit(g_tx_en, g_tx_slot, g_slot);
        rx_hit    = slot_hit(g_rx_en, g_rx_slot, g_slot);

        slot_d       = SLOT_CNT;
        tick_d       = TICK_CNT;
        tick_pulse_d = 1'b0;
        frame_d      = 1'b0;
        txg_d        = 1'b0;
        rxg_d        = 1'b0;
        col_d        = COLLIDE;
        int_d        = slot_tick ? 1'b1 : (int_ack ? 1'b0 : TPU_INT);

        if (RSTTPU) begin
            slot_d = 8'd0;
            tick_d = 16'd0;
            int_d  = 1'b0;
            col_d  = 1'b0;
        end else if (state_d == IDLE) begin
            slot_d = 8'd0;
            tick_d = 16'd0;
        end else begin
            txg_d = tx_hit;
            rxg_d = rx_hit && !tx_hit;
            col_d = COLLIDE || (tx_hit && rx_hit);
            if (load) begin
                slot_d       = slot_nxt;
                tick_d       = 16'd0;
                tick_pulse_d = 1'b1;
                frame_d      = (slot_nxt == 8'd0);
            end else begin
                tick_d = TICK_CNT + 16'd1;
            end
        end
    end

    always_ff @(posedge SYS_CLK) begin
        if (SYS_RST) begin
            state_q     <= IDLE;
            SLOT_CNT    <= 8'd0;
            TICK_CNT    <= 16'd0;
            slot_tick   <= 1'b0;
            frame_start <= 1'b0;
            TX_GATE     <= 1'b0;
            RX_GATE     <= 1'b0;
            TPU_INT     <= 1'b0;
            COLLIDE     <= 1'b0;
            sh_period   <= 16'd0;
            sh_tx_slot  <= 8'd0;
            sh_rx_slot  <= 8'd0;
            sh_tx_en    <= 1'b0;
            sh_rx_en    <= 1'b0;
        end else begin
            state_q     <= state_d;
            SLOT_CNT    <= slot_d;
            TICK_CNT    <= tick_d;
            slot_tick   <= tick_pulse_d;
            frame_start <= frame_d;
            TX_GATE     <= txg_d;
            RX_GATE     <= rxg_d;
            TPU_INT     <= int_d;
            COLLIDE     <= col_d;
            if (load) begin
                sh_period  <= TIMER_INT_VALUE;
                sh_tx_slot <= TX_SLOT;
                sh_rx_slot <= RX_SLOT;
                sh_tx_en   <= TXSLOT_EN;
                sh_rx_en   <= RXSLOT_EN;
            end
        end
    end

endmodule

// File: tb/tb_tpu_slot_sched.sv
// Bench for tpu_slot_sched: slot-level reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_tpu_slot_sched;

    localparam int SLOTS = 16;

    logic        SYS_CLK, SYS_RST, RSTTPU, TXSLOT_EN, RXSLOT_EN, int_ack;
    logic [7:0]  TX_SLOT, RX_SLOT;
    logic [15:0] TIMER_INT_VALUE;
    logic [7:0]  SLOT_CNT;
    logic [15:0] TICK_CNT;
    logic        slot_tick, frame_start, TX_GATE, RX_GATE, TPU_INT, COLLIDE;
    logic [29:0] dut_vec;

    int n_checks = 0;
    int n_fail   = 0;

    tpu_slot_sched #(.SLOTS_PER_FRAME(SLOTS)) dut (
        .SYS_CLK(SYS_CLK), .SYS_RST(SYS_RST), .RSTTPU(RSTTPU),
        .TXSLOT_EN(TXSLOT_EN), .RXSLOT_EN(RXSLOT_EN),
        .TX_SLOT(TX_SLOT), .RX_SLOT(RX_SLOT),
        .TIMER_INT_VALUE(TIMER_INT_VALUE), .int_ack(int_ack),
        .SLOT_CNT(SLOT_CNT), .TICK_CNT(TICK_CNT), .slot_tick(slot_tick),
        .frame_start(frame_start), .TX_GATE(TX_GATE), .RX_GATE(RX_GATE),
        .TPU_INT(TPU_INT), .COLLIDE(COLLIDE)
    );

    assign dut_vec = {SLOT_CNT, TICK_CNT, slot_tick, frame_start, TX_GATE, RX_GATE, TPU_INT, COLLIDE};

    initial begin
        SYS_CLK = 1'b0;
        forever #5 SYS_CLK = ~SYS_CLK;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a slot is a countdown of its captured length.
    bit m_run, m_txe, m_rxe, m_st, m_fs, m_int, m_col;
    int m_slot, m_left, m_len, m_tx, m_rx;

    task automatic m_start(input int s, input int len, input int tx, input int rx,
                           input bit txe, input bit rxe);
        m_run = 1; m_slot = s; m_len = len; m_left = len;
        m_tx = tx; m_rx = rx; m_txe = txe; m_rxe = rxe;
        m_st = 1; m_fs = (s == 0);
        if (txe && rxe && tx == s && rx == s) m_col = 1;
    endtask

    initial begin
        bit r, t, ack, txe, rxe, tg, rg;
        int tv, txs, rxs, es, et;
        logic [29:0] exp_vec;
        m_run = 0; m_slot = 0; m_left = 0; m_len = 0; m_tx = 0; m_rx = 0;
        m_txe = 0; m_rxe = 0; m_st = 0; m_fs = 0; m_int = 0; m_col = 0;
        forever begin
            @(posedge SYS_CLK);
            r = SYS_RST; t = RSTTPU; ack = int_ack; txe = TXSLOT_EN; rxe = RXSLOT_EN;
            tv = int'(TIMER_INT_VALUE); txs = int'(TX_SLOT); rxs = int'(RX_SLOT);
            if (r) begin
                m_run = 0; m_st = 0; m_fs = 0; m_int = 0; m_col = 0; m_txe = 0; m_rxe = 0;
            end else begin
                m_int = m_st ? 1'b1 : (ack ? 1'b0 : m_int);
                m_st = 0; m_fs = 0;
                if (t) begin
                    m_run = 0; m_int = 0; m_col = 0;
                end else if (!m_run) begin
                    if (tv != 0) m_start(0, tv, txs, rxs, txe, rxe);
                end else if (m_left == 1) begin
                    if (tv == 0) m_run = 0;
                    else m_start((m_slot + 1) % SLOTS, tv, txs, rxs, txe, rxe);
                end else begin
                    m_left--;
                end
            end
            #1;
            es = m_run ? m_slot : 0;
            et = m_run ? m_len - m_left : 0;
            tg = m_run && m_txe && m_tx == m_slot;
            rg = m_run && m_rxe && m_rx == m_slot && !tg;
            exp_vec = {8'(es), 16'(et), m_st && m_run, m_fs && m_run, tg, rg, m_int, m_col};
            check("outputs", int'(dut_vec), int'(exp_vec));
        end
    end

    task automatic restart();
        @(negedge SYS_CLK); RSTTPU = 1'b1;
        @(negedge SYS_CLK); RSTTPU = 1'b0;
    endtask

    initial begin
        int c0, c1, c2, c3;
        SYS_RST = 1'b1; RSTTPU = 1'b1; TXSLOT_EN = 1'b0; RXSLOT_EN = 1'b0;
        TX_SLOT = 8'd0; RX_SLOT = 8'd0; TIMER_INT_VALUE = 16'd4; int_ack = 1'b0;
        repeat (3) @(negedge SYS_CLK);
        check("rst_vec", int'(dut_vec), 0);
        SYS_RST = 1'b0;

        // Start-up: period 4, 16 slots per frame
        restart();
        c0 = 0; c1 = 0;
        for (int i = 0; i <= 64; i++) begin
            @(negedge SYS_CLK);
            if (i < 64 && slot_tick) c0++;
            if (frame_start) c1++;
            if (i == 0)  check("first_cycle", int'({SLOT_CNT, TICK_CNT, slot_tick, frame_start}), 3);
            if (i == 63) check("slot15", int'(SLOT_CNT), 15);
            if (i == 64) check("wrap_slot0", int'({SLOT_CNT, frame_start}), 1);
        end
        check("ticks_per_frame", c0, 16);
        check("frame_starts", c1, 2);

        // TX slot 3, RX slot 5
        TX_SLOT = 8'd3; RX_SLOT = 8'd5; TXSLOT_EN = 1'b1; RXSLOT_EN = 1'b1;
        restart();
        c0 = 0; c1 = 0; c2 = 0; c3 = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge SYS_CLK);
            if (TX_GATE) begin c0++; if (SLOT_CNT != 8'd3) c1++; end
            if (RX_GATE) begin c2++; if (SLOT_CNT != 8'd5) c3++; end
        end
        check("tx_cycles", c0, 4);
        check("tx_wrong_slot", c1, 0);
        check("rx_cycles", c2, 4);
        check("rx_wrong_slot", c3, 0);
        check("no_collide", int'(COLLIDE), 0);

        // Collision in slot 2
        TX_SLOT = 8'd2; RX_SLOT = 8'd2;
        restart();
        c0 = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge SYS_CLK);
            if (SLOT_CNT == 8'd2 && TX_GATE && !RX_GATE) c0++;
            if (i == 7) check("collide_before", int'(COLLIDE), 0);
            if (i == 8) check("collide_set", int'(COLLIDE), 1);
        end
        check("tx_priority", c0, 4);
        check("collide_sticky", int'(COLLIDE), 1);

        // Out-of-range TX slot
        TX_SLOT = 8'd200; RXSLOT_EN = 1'b0;
        restart();
        c0 = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge SYS_CLK);
            if (TX_GATE) c0++;
        end
        check("tx200_never", c0, 0);
        check("collide_cleared", int'(COLLIDE), 0);

        // Mid-slot period change 4 -> 2
        TXSLOT_EN = 1'b0; TIMER_INT_VALUE = 16'd4;
        restart();
        for (int i = 0; i < 10; i++) begin
            @(negedge SYS_CLK);
            if (i == 1) begin
                check("mid_tick1", int'(TICK_CNT), 1);
                TIMER_INT_VALUE = 16'd2;
            end
            if (i == 3) check("old_len_tick3", int'(TICK_CNT), 3);
            if (i == 4) check("slot1_start", int'({SLOT_CNT, slot_tick}), 3);
            if (i == 6) check("slot2_start", int'({SLOT_CNT, slot_tick}), 5);
            if (i == 8) check("slot3_start", int'({SLOT_CNT, slot_tick}), 7);
        end

        // Period 1
        TIMER_INT_VALUE = 16'd1;
        restart();
        c0 = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge SYS_CLK);
            if (slot_tick && TICK_CNT == 16'd0) c0++;
            if (i == 5) check("p1_slot5", int'(SLOT_CNT), 5);
        end
        check("p1_ticks", c0, 6);

        // Interrupt set/ack
        TIMER_INT_VALUE = 16'd4;
        restart();
        for (int i = 0; i < 6; i++) begin
            @(negedge SYS_CLK);
            if (i == 0) begin
                check("int_before_set", int'({slot_tick, TPU_INT}), 2);
                int_ack = 1'b1;
            end
            if (i == 1) check("int_set_wins", int'(TPU_INT), 1);
            if (i == 2) begin
                check("int_cleared", int'(TPU_INT), 0);
                int_ack = 1'b0;
            end
            if (i == 4) check("int_still_clear", int'(TPU_INT), 0);
            if (i == 5) check("int_reset", int'(TPU_INT), 1);
        end

        // RSTTPU mid-slot
        TX_SLOT = 8'd0; TXSLOT_EN = 1'b1;
        restart();
        @(negedge SYS_CLK);
        check("gate_slot0", int'(TX_GATE), 1);
        @(negedge SYS_CLK);
        RSTTPU = 1'b1;
        @(negedge SYS_CLK);
        check("rsttpu_vec", int'(dut_vec), 0);
        RSTTPU = 1'b0;

        // Stop at boundary with period 0
        restart();
        for (int i = 0; i < 6; i++) begin
            @(negedge SYS_CLK);
            if (i == 1) TIMER_INT_VALUE = 16'd0;
            if (i == 3) check("stop_tick3", int'(TICK_CNT), 3);
            if (i == 4) check("stop_idle", int'({SLOT_CNT, TICK_CNT, slot_tick, TX_GATE}), 0);
            if (i == 5) check("stop_held", int'(TICK_CNT), 0);
        end

        // SYS_RST mid-run
        TIMER_INT_VALUE = 16'd4;
        restart();
        @(negedge SYS_CLK);
        @(negedge SYS_CLK);
        check("run_int_set", int'({TX_GATE, TPU_INT}), 3);
        SYS_RST = 1'b1;
        @(negedge SYS_CLK);
        check("sysrst_vec", int'(dut_vec), 0);
        SYS_RST = 1'b0;
        repeat (4) @(negedge SYS_CLK);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
